// File: rtl/filter_mode_sequencer.sv
// filter_mode_sequencer
//   Control for the colour-channel filter stage. The board switches are
//   synchronised and debounced. An accepted setting is held pending and is
//   applied only at a frame start, so the picture never tears. Mode 11 steps
//   through the six RGB channel permutations every FRAMES_PER_STEP frames.
// Ports
//   iCLK          system clock, rising edge
//   iRST          asynchronous active-high reset
//   iSW[9:0]      raw board switches (asynchronous)
//   iFRAME_START  one-cycle frame-start pulse (vsync)
//   oSW_FILT[9:0] select word to the filter datapath
//   oMODE[1:0]    applied mode: 00 bypass, 10 swap, 01 permutation, 11 auto
//   oPERM[2:0]    applied permutation index
//   oPENDING      accepted setting waiting for the next frame start
//   oSTEP         one-cycle pulse when auto mode advances oPERM
module filter_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYC    = 500000,
  parameter int unsigned FRAMES_PER_STEP = 30
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [9:0] iSW,
  input  logic       iFRAME_START,
  output logic [9:0] oSW_FILT,
  output logic [1:0] oMODE,
  output logic [2:0] oPERM,
  output logic       oPENDING,
  output logic       oSTEP
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned FCNT_W = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_STEP - 1);

  typedef enum logic {
    S_STABLE   = 1'b0,
    S_DEBOUNCE = 1'b1
  } state_t;

  // Synchroniser
  logic [9:0] r_sw_meta;
  logic [9:0] r_sw_s;

  // Debounce state
  state_t           r_state;
  logic [9:0]       r_sw_db;
  logic [9:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nx;
  logic [9:0]       w_cand_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_accept;

  // Apply / auto-cycle state
  logic [9:0]        r_pend_cfg;
  logic              r_pending;
  logic [1:0]        r_mode;
  logic [2:0]        r_perm;
  logic [9:0]        r_sw_filt;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_step;
  logic [2:0]        w_perm_nx;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_sw_meta <= '0;
      r_sw_s    <= '0;
    end else begin
      r_sw_meta <= iSW;
      r_sw_s    <= r_sw_meta;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_STABLE;
      r_sw_db <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_sw_db <= r_sw_s;
      end
    end
  end

  // The entry cycle into S_DEBOUNCE already counts as the first stable
  // sample, so the acceptance test is on the incremented count. With
  // DEBOUNCE_CYC == 1 the first differing sample is accepted directly.
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_STABLE: begin
        if (r_sw_s != r_sw_db) begin
          w_cand_nx = r_sw_s;
          w_cnt_nx  = '0;
          if (DEBOUNCE_CYC == 1) begin
            w_accept = 1'b1;
          end else begin
            w_state_nx = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (r_sw_s == r_sw_db) begin
          w_state_nx = S_STABLE;
        end else if (r_sw_s != r_cand) begin
          w_cand_nx = r_sw_s;
          w_cnt_nx  = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
          if (w_cnt_nx == CNT_LAST) begin
            w_accept   = 1'b1;
            w_state_nx = S_STABLE;
          end
        end
      end
      default: w_state_nx = S_STABLE;
    endcase
  end

  assign w_perm_nx = (r_perm == 3'd5) ? 3'd0 : r_perm + 3'd1;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pend_cfg <= '0;
      r_pending  <= 1'b0;
      r_mode     <= '0;
      r_perm     <= '0;
      r_sw_filt  <= '0;
      r_fcnt     <= '0;
      r_step     <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (iFRAME_START && r_pending) begin
        r_mode <= r_pend_cfg[9:8];
        r_fcnt <= '0;
        case (r_pend_cfg[9:8])
          2'b11: begin
            r_perm    <= '0;
            r_sw_filt <= {2'b01, 5'b00000, 3'b000};
          end
          2'b00: begin
            r_perm    <= '0;
            r_sw_filt <= r_pend_cfg;
          end
          default: begin
            r_perm    <= r_pend_cfg[2:0];
            r_sw_filt <= r_pend_cfg;
          end
        endcase
      end else if (iFRAME_START && (r_mode == 2'b11)) begin
        if (r_fcnt == FCNT_LAST) begin
          r_fcnt         <= '0;
          r_perm         <= w_perm_nx;
          r_sw_filt[2:0] <= w_perm_nx;
          r_step         <= 1'b1;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end

      // A fresh acceptance wins over clearing, so one that lands on a
      // frame-start cycle stays pending for the following frame.
      if (w_accept) begin
        r_pend_cfg <= r_sw_s;
        r_pending  <= 1'b1;
      end else if (iFRAME_START) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign oSW_FILT = r_sw_filt;
  assign oMODE    = r_mode;
  assign oPERM    = r_perm;
  assign oPENDING = r_pending;
  assign oSTEP    = r_step;

endmodule

// File: tb/tb_filter_mode_sequencer.sv
module tb_filter_mode_sequencer;

  localparam int unsigned DEB = 4;
  localparam int unsigned FPS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw  = 10'h100;
  logic       fs  = 1'b0;
  logic [9:0] oSW_FILT;
  logic [1:0] oMODE;
  logic [2:0] oPERM;
  logic       oPENDING;
  logic       oSTEP;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  filter_mode_sequencer #(
    .DEBOUNCE_CYC   (DEB),
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iSW         (sw),
    .iFRAME_START(fs),
    .oSW_FILT    (oSW_FILT),
    .oMODE       (oMODE),
    .oPERM       (oPERM),
    .oPENDING    (oPENDING),
    .oSTEP       (oSTEP)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] filt;
    logic [1:0] mode;
    logic [2:0] perm;
    logic       pend;
    logic       step;
  } out_t;

  out_t exp_q[$];

  // Reference model: a two-stage delay line for the synchroniser, a
  // run-length count of identical synced samples for the debounce, and a
  // frames-since-step counter for auto mode.
  logic [9:0] m_s1, m_s2, m_db, m_rval, m_pcfg, m_cfg;
  int         m_run, m_fc;
  logic       m_pend, m_step;
  logic [1:0] m_mode;
  logic [2:0] m_perm;

  always @(posedge clk) begin
    logic [9:0] s;
    bit         acc;
    out_t       e;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rval = '0; m_pcfg = '0; m_cfg = '0;
      m_run = 0; m_fc = 0; m_pend = 0; m_step = 0; m_mode = '0; m_perm = '0;
    end else begin
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = sw;
      acc  = 0;
      if (s == m_db) m_run = 0;
      else if (m_run > 0 && s == m_rval) m_run++;
      else begin
        m_rval = s;
        m_run  = 1;
      end
      if (m_run == int'(DEB)) begin
        acc   = 1;
        m_db  = s;
        m_run = 0;
      end
      m_step = 0;
      if (fs && m_pend) begin
        m_cfg  = m_pcfg;
        m_mode = m_pcfg[9:8];
        m_fc   = 0;
        m_perm = (m_mode == 2'b11 || m_mode == 2'b00) ? 3'd0 : m_pcfg[2:0];
      end else if (fs && m_mode == 2'b11) begin
        m_fc++;
        if (m_fc == int'(FPS)) begin
          m_fc   = 0;
          m_perm = 3'((int'(m_perm) + 1) % 6);
          m_step = 1;
        end
      end
      if (acc) begin
        m_pcfg = s;
        m_pend = 1;
      end else if (fs) begin
        m_pend = 0;
      end
    end
    e.filt = (m_mode == 2'b11) ? {2'b01, 5'b00000, m_perm} : m_cfg;
    e.mode = m_mode;
    e.perm = m_perm;
    e.pend = m_pend;
    e.step = m_step;
    exp_q.push_back(e);
  end

  // Monitor: the outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    out_t e, a;
    if (!done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        if (rst) e = '0;
        a = {oSW_FILT, oMODE, oPERM, oPENDING, oSTEP};
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got filt=%h mode=%b perm=%0d pend=%b step=%b expected filt=%h mode=%b perm=%0d pend=%b step=%b",
                   $time, a.filt, a.mode, a.perm, a.pend, a.step,
                   e.filt, e.mode, e.perm, e.pend, e.step);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic frame();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  initial begin
    // 1: reset with switches already set, then latency to pending and apply
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) tick();
    chk("t1_pend_cycle5", 32'(oPENDING), 32'd0);
    tick();
    chk("t1_pend_cycle6", 32'(oPENDING), 32'd1);
    frame();
    chk("t1_filt", 32'(oSW_FILT), 32'h100);
    chk("t1_mode", 32'(oMODE), 32'd1);
    chk("t1_perm", 32'(oPERM), 32'd0);

    // 2: bouncing switch, then a clean hold
    repeat (6) begin
      sw = 10'h102; tick(); tick();
      sw = 10'h100; tick(); tick();
    end
    repeat (3) tick();
    chk("t2_no_accept_bounce", 32'(oPENDING), 32'd0);
    sw = 10'h102;
    repeat (5) tick();
    chk("t2_pend_early", 32'(oPENDING), 32'd0);
    tick();
    chk("t2_pend_accept", 32'(oPENDING), 32'd1);
    frame();
    chk("t2_filt", 32'(oSW_FILT), 32'h102);
    chk("t2_perm", 32'(oPERM), 32'd2);

    // 4: acceptance on the same edge as a frame start
    sw = 10'h0A5;
    repeat (5) tick();
    frame();
    chk("t4_pend_kept", 32'(oPENDING), 32'd1);
    chk("t4_filt_unchanged", 32'(oSW_FILT), 32'h102);
    chk("t4_mode_unchanged", 32'(oMODE), 32'd1);
    repeat (3) tick();
    frame();
    chk("t4_filt_applied", 32'(oSW_FILT), 32'h0A5);
    chk("t4_mode_applied", 32'(oMODE), 32'd0);

    // 3: auto-cycle through the six permutations
    sw = 10'h300;
    repeat (8) tick();
    for (int i = 0; i < 14; i++) begin
      frame();
      chk($sformatf("t3_filt_f%0d", i), 32'(oSW_FILT), 32'h100 + 32'((i / 2) % 6));
      chk($sformatf("t3_step_f%0d", i), 32'(oSTEP), 32'((i > 0) && (i % 2 == 0)));
      repeat (19) tick();
    end

    // 6: two acceptances within one frame, only the later applies
    sw = 10'h200;
    repeat (8) tick();
    sw = 10'h001;
    repeat (8) tick();
    frame();
    chk("t6_filt", 32'(oSW_FILT), 32'h001);
    chk("t6_mode", 32'(oMODE), 32'd0);

    // 5: reset mid-auto-cycle and mid-debounce
    sw = 10'h300;
    repeat (8) tick();
    repeat (5) begin frame(); repeat (4) tick(); end
    sw = 10'h2C3;
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    chk("t5_async_zero", {17'd0, oSW_FILT, oMODE, oPERM, oPENDING, oSTEP}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("t5_redebounce_early", 32'(oPENDING), 32'd0);
    tick();
    chk("t5_redebounce_accept", 32'(oPENDING), 32'd1);
    frame();
    chk("t5_filt", 32'(oSW_FILT), 32'h2C3);
    chk("t5_perm", 32'(oPERM), 32'd3);

    // Random phase against the reference model
    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        sw = 10'($urandom);
        tick();
      end else if (r < 4) begin
        frame();
      end else begin
        repeat ($urandom_range(1, 6)) tick();
      end
    end

    repeat (3) tick();
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
